// File: rtl/aes_dec_scheduler.sv
// ---------------------------------------------------------------------------
// AesDecScheduler (module aes_dec_scheduler)
//
// Front-end scheduler for a shared AES inverse-round datapath. Two requesters
// compete for the datapath through a round-robin arbiter. One ciphertext block
// is in flight at a time. The scheduler drives the datapath through LOAD, then
// Nr-1 inverse rounds, then the final round. It then holds the plaintext on
// the output port until the consumer takes it.
//
// Ports:
//   clk                    single clock, rising edge
//   decReset               synchronous active-high reset
//   req0_valid/data/ready  requester 0 ciphertext handshake
//   req1_valid/data/ready  requester 1 ciphertext handshake
//   dp_in                  latched ciphertext towards the datapath
//   dp_load                datapath: state = dp_in ^ initial round key
//   dp_step                datapath: apply one inverse round
//   dp_last                datapath: apply the final inverse round
//   dp_round               current round index (0..Nr)
//   dp_result              datapath output, valid during FINAL
//   out_valid/ready        plaintext handshake
//   out_data               plaintext block
//   out_id                 requester that owns out_data
//   busy                   high whenever a block is being processed
// ---------------------------------------------------------------------------
module aes_dec_scheduler #(
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         decReset,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic [127:0] dp_in,
  output logic         dp_load,
  output logic         dp_step,
  output logic         dp_last,
  output logic [3:0]   dp_round,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_id,
  output logic         busy
);

  localparam int         NrInt = Nk + 6;
  localparam logic [3:0] NR    = 4'(NrInt);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    OUT
  } state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic         r_ptr;
  logic         r_owner;
  logic         r_outId;
  logic [3:0]   r_round;
  logic [127:0] r_dpIn;
  logic [127:0] r_outData;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;

  // Round-robin grant. A lone valid requester always wins. When both are
  // valid, the pointer picks the winner, and it then flips to the loser.
  assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
  assign w_grant1 = req1_valid & (~req0_valid | r_ptr);
  assign w_accept = (r_state == IDLE) & ~decReset & (w_grant0 | w_grant1);

  // Next-state and per-state strobes. Readies exist only in IDLE and are
  // masked by reset. At most one datapath strobe is active in any state.
  always_comb begin
    w_nextState = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    dp_load     = 1'b0;
    dp_step     = 1'b0;
    dp_last     = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0 & ~decReset;
        req1_ready = w_grant1 & ~decReset;
        if (w_accept) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        dp_load     = 1'b1;
        w_nextState = ROUND;
      end
      ROUND: begin
        dp_step = 1'b1;
        if (r_round == NR - 4'd1) begin
          w_nextState = FINAL;
        end
      end
      FINAL: begin
        dp_last     = 1'b1;
        w_nextState = OUT;
      end
      OUT: begin
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register, arbitration pointer, block capture and round counter.
  // The round counter runs 1..Nr-1 through ROUND. It lands on Nr as the FSM
  // enters FINAL and holds Nr through OUT. It returns to 0 with IDLE.
  always_ff @(posedge clk) begin
    if (decReset) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_round   <= 4'd0;
      r_dpIn    <= '0;
      r_outData <= '0;
      r_outId   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_ptr   <= ~w_grant1;
        r_owner <= w_grant1;
        r_dpIn  <= w_grant1 ? req1_data : req0_data;
      end
      case (r_state)
        IDLE:  r_round <= 4'd0;
        LOAD:  r_round <= 4'd1;
        ROUND: r_round <= r_round + 4'd1;
        FINAL: begin
          r_outData <= dp_result;
          r_outId   <= r_owner;
        end
        OUT: begin
          if (out_ready) begin
            r_round <= 4'd0;
          end
        end
        default: r_round <= 4'd0;
      endcase
    end
  end

  assign dp_in     = r_dpIn;
  assign dp_round  = r_round;
  assign out_valid = (r_state == OUT);
  assign out_data  = r_outData;
  assign out_id    = r_outId;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// ---------------------------------------------------------------------------
// TbAesDecScheduler (module tb_aes_dec_scheduler)
//
// Bench for the AES decryption scheduler. One instance uses Nk=4 and a second
// uses Nk=8. Each instance drives a behavioural AES inverse-round datapath
// that is built from first principles: GF(2^8) arithmetic, a derived S-box and
// key expansion. The expected results come from the arbitration rules and the
// timeline of a block, not from the RTL's structure.
// ---------------------------------------------------------------------------
module tb_aes_dec_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic decReset;

  logic         req0Valid4, req1Valid4, req0Ready4, req1Ready4;
  logic [127:0] req0Data4, req1Data4, dpIn4, dpResult4, outData4;
  logic         dpLoad4, dpStep4, dpLast4, outValid4, outReady4, outId4, busy4;
  logic [3:0]   dpRound4;

  logic         req0Valid8, req1Valid8, req0Ready8, req1Ready8;
  logic [127:0] req0Data8, req1Data8, dpIn8, dpResult8, outData8;
  logic         dpLoad8, dpStep8, dpLast8, outValid8, outReady8, outId8, busy8;
  logic [3:0]   dpRound8;

  int checks   = 0;
  int errors   = 0;
  int modelPtr = 0;
  int lastOutId;

  logic [7:0]   sboxTab[0:255];
  logic [7:0]   invSboxTab[0:255];
  logic [127:0] rkTmp[0:14];
  logic [127:0] rk4[0:10];
  logic [127:0] rk8[0:14];
  logic [127:0] dpState4, dpState8;

  localparam logic [255:0] KEY4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY8 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  aes_dec_scheduler #(.Nk(4)) u_dut4 (
    .clk(clk), .decReset(decReset),
    .req0_valid(req0Valid4), .req0_data(req0Data4), .req0_ready(req0Ready4),
    .req1_valid(req1Valid4), .req1_data(req1Data4), .req1_ready(req1Ready4),
    .dp_in(dpIn4), .dp_load(dpLoad4), .dp_step(dpStep4), .dp_last(dpLast4),
    .dp_round(dpRound4), .dp_result(dpResult4),
    .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
    .out_id(outId4), .busy(busy4)
  );

  aes_dec_scheduler #(.Nk(8)) u_dut8 (
    .clk(clk), .decReset(decReset),
    .req0_valid(req0Valid8), .req0_data(req0Data8), .req0_ready(req0Ready8),
    .req1_valid(req1Valid8), .req1_data(req1Data8), .req1_ready(req1Ready8),
    .dp_in(dpIn8), .dp_load(dpLoad8), .dp_step(dpStep8), .dp_last(dpLast8),
    .dp_round(dpRound8), .dp_result(dpResult8),
    .out_valid(outValid8), .out_ready(outReady8), .out_data(outData8),
    .out_id(outId8), .busy(busy8)
  );

  logic [10:0] ctl4, ctl8;
  assign ctl4 = {busy4, req0Ready4, req1Ready4, dpLoad4, dpStep4, dpLast4, dpRound4, outValid4};
  assign ctl8 = {busy8, req0Ready8, req1Ready8, dpLoad8, dpStep8, dpLast8, dpRound8, outValid8};

  // GF(2^8) multiply modulo the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // The S-box is the multiplicative inverse followed by the affine map. The
  // inverse S-box is obtained by inverting that table.
  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      r = inv;
      s = inv;
      repeat (4) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      s = s ^ 8'h63;
      sboxTab[x]    = s;
      invSboxTab[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  // Standard key expansion. The key is left-aligned in a 256-bit vector, and
  // the round keys are written into rkTmp.
  task automatic expandKey(input int nk, input logic [255:0] key);
    logic [31:0] w[0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkTmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = invSboxTab[s[127 - 8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      o[119 - 32*c -: 8] = gmul(a0, 8'd9) ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      o[111 - 32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9) ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      o[103 - 32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9) ^ gmul(a3, 8'd14);
    end
    return o;
  endfunction

  function automatic logic [127:0] invRound(input logic [127:0] s, input logic [127:0] k);
    return invMixColumns(invSubBytes(invShiftRows(s)) ^ k);
  endfunction

  function automatic logic [127:0] invFinal(input logic [127:0] s, input logic [127:0] k);
    return invSubBytes(invShiftRows(s)) ^ k;
  endfunction

  // Complete AES-128 decryption, used as the expected plaintext for random
  // blocks.
  function automatic logic [127:0] decrypt4(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk4[10];
    for (int r = 9; r >= 1; r--) s = invRound(s, rk4[r]);
    return invFinal(s, rk4[0]);
  endfunction

  // Shared datapath stand-ins. They follow the load/step/last strobes and
  // choose the round key from the scheduler's round index.
  always @(posedge clk) begin
    if (dpLoad4) dpState4 <= dpIn4 ^ rk4[10];
    else if (dpStep4 && dpRound4 >= 4'd1 && dpRound4 <= 4'd10)
      dpState4 <= invRound(dpState4, rk4[10 - int'(dpRound4)]);
  end
  assign dpResult4 = invFinal(dpState4, rk4[0]);

  always @(posedge clk) begin
    if (dpLoad8) dpState8 <= dpIn8 ^ rk8[14];
    else if (dpStep8 && dpRound8 >= 4'd1 && dpRound8 <= 4'd14)
      dpState8 <= invRound(dpState8, rk8[14 - int'(dpRound8)]);
  end
  assign dpResult8 = invFinal(dpState8, rk8[0]);

  // Expected control word {busy, rdy0, rdy1, load, step, last, round, valid}
  // for cycle c of a block. Cycle 0 is the IDLE cycle that accepts, and
  // cycle 1 is the one right after the accept edge.
  function automatic logic [10:0] expCtl(input int c, input int nr, input bit r0, input bit r1);
    logic [3:0] rnd;
    if (c == 0) return {1'b0, r0, r1, 3'b000, 4'd0, 1'b0};
    if (c == 1) return {1'b1, 2'b00, 3'b100, 4'd0, 1'b0};
    if (c <= nr) begin
      rnd = 4'(c - 1);
      return {1'b1, 2'b00, 3'b010, rnd, 1'b0};
    end
    rnd = 4'(nr);
    if (c == nr + 1) return {1'b1, 2'b00, 3'b001, rnd, 1'b0};
    return {1'b1, 2'b00, 3'b000, rnd, 1'b1};
  endfunction

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete Nk=4 transaction, from the IDLE offer to the consumer
  // handshake. The grant comes from the round-robin rules. With keepValid
  // clear, the valids drop after the accept and the data is scrambled, which
  // shows that the data was sampled only on the accept edge.
  task automatic applyStimulus(input bit v0, input bit v1, input logic [127:0] d0,
                               input logic [127:0] d1, input int stall, input bit keepValid,
                               input bit useKnown, input logic [127:0] knownPt);
    int           g;
    logic [127:0] ct;
    logic [127:0] exp;
    g = (v0 && v1) ? modelPtr : (v1 ? 1 : 0);
    ct = (g == 1) ? d1 : d0;
    exp = useKnown ? knownPt : decrypt4(ct);
    req0Valid4 = v0;
    req1Valid4 = v1;
    req0Data4  = d0;
    req1Data4  = d1;
    outReady4  = 1'b0;
    #1;
    checkOutput("idle_ready", 128'(ctl4), 128'(expCtl(0, 10, g == 0, g == 1)));
    tick();
    modelPtr = 1 - g;
    checkOutput("dp_in_latch", dpIn4, ct);
    if (!keepValid) begin
      req0Valid4 = 1'b0;
      req1Valid4 = 1'b0;
      req0Data4  = {$urandom, $urandom, $urandom, $urandom};
      req1Data4  = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int c = 1; c <= 12; c++) begin
      checkOutput($sformatf("ctl_c%0d", c), 128'(ctl4), 128'(expCtl(c, 10, 1'b0, 1'b0)));
      if (c < 12) tick();
    end
    checkOutput("out_data", outData4, exp);
    checkOutput("out_id", 128'(outId4), 128'(g));
    for (int s = 0; s < stall; s++) begin
      tick();
      checkOutput("stall_ctl", 128'(ctl4), 128'(expCtl(12, 10, 1'b0, 1'b0)));
      checkOutput("stall_data", outData4, exp);
      checkOutput("stall_id", 128'(outId4), 128'(g));
      checkOutput("stall_dp_in", dpIn4, ct);
    end
    lastOutId = int'(outId4);
    outReady4 = 1'b1;
    tick();
    outReady4 = 1'b0;
    checkOutput("after_out", 128'({busy4, outValid4, dpRound4}), 128'(0));
  endtask

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    bit           v0;
    bit           v1;

    buildTables();
    expandKey(4, KEY4);
    for (int i = 0; i <= 10; i++) rk4[i] = rkTmp[i];
    expandKey(8, KEY8);
    for (int i = 0; i <= 14; i++) rk8[i] = rkTmp[i];

    req0Data8 = '0; req1Data8 = '0; req0Valid8 = 1'b0; req1Valid8 = 1'b0; outReady8 = 1'b0;
    outReady4 = 1'b0;
    req0Data4 = {$urandom, $urandom, $urandom, $urandom};
    req1Data4 = {$urandom, $urandom, $urandom, $urandom};
    decReset   = 1'b1;
    req0Valid4 = 1'b1;
    req1Valid4 = 1'b1;
    tick();
    tick();
    $display("[TB] reset checks");
    checkOutput("rst_ctl", 128'(ctl4), 128'(0));
    checkOutput("rst_dp_in", dpIn4, 128'(0));
    checkOutput("rst_out_data", outData4, 128'(0));
    checkOutput("rst_out_id", 128'(outId4), 128'(0));
    checkOutput("rst_ctl8", 128'(ctl8), 128'(0));
    req0Valid4 = 1'b0;
    req1Valid4 = 1'b0;
    decReset   = 1'b0;
    tick();

    $display("[TB] both requesters continuously valid");
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 1'b1, a, b, 0, 1'b1, 1'b0, '0);
      checkOutput("alternate_id", 128'(lastOutId), 128'(i % 2));
    end

    $display("[TB] known AES-128 vector with a five-cycle output stall");
    applyStimulus(1'b1, 1'b0, CT4, '0, 5, 1'b0, 1'b1, PT);

    $display("[TB] reset in flight");
    req0Valid4 = 1'b1;
    req1Valid4 = 1'b0;
    req0Data4  = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checkOutput("rif_ready", 128'(ctl4), 128'(expCtl(0, 10, 1'b1, 1'b0)));
    tick();
    req0Valid4 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checkOutput("rif_ctl", 128'(ctl4), 128'(expCtl(c, 10, 1'b0, 1'b0)));
      if (c < 6) tick();
    end
    decReset = 1'b1;
    tick();
    decReset = 1'b0;
    modelPtr = 0;
    checkOutput("rif_after", 128'(ctl4), 128'(0));
    for (int c = 0; c < 13; c++) begin
      tick();
      checkOutput("rif_no_out", 128'(ctl4), 128'(0));
    end
    req0Valid4 = 1'b1;
    req1Valid4 = 1'b1;
    #1;
    checkOutput("rif_ptr", 128'(ctl4), 128'(expCtl(0, 10, 1'b1, 1'b0)));
    b = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, 1'b1, '0, b, 0, 1'b0, 1'b0, '0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(v0, v1, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0);
    end

    $display("[TB] Nk=8 known vector");
    req0Valid8 = 1'b1;
    req0Data8  = CT8;
    #1;
    checkOutput("nk8_ready", 128'(ctl8), 128'(expCtl(0, 14, 1'b1, 1'b0)));
    tick();
    req0Valid8 = 1'b0;
    req0Data8  = '0;
    for (int c = 1; c <= 16; c++) begin
      checkOutput($sformatf("nk8_ctl_c%0d", c), 128'(ctl8), 128'(expCtl(c, 14, 1'b0, 1'b0)));
      if (c < 16) tick();
    end
    checkOutput("nk8_out_data", outData8, PT);
    checkOutput("nk8_out_id", 128'(outId8), 128'(0));
    outReady8 = 1'b1;
    tick();
    outReady8 = 1'b0;
    checkOutput("nk8_after", 128'(ctl8), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_dec_scheduler.md
AES_DEC_SCHEDULER -- requirements
Module: aes_dec_scheduler

Interface
REQ-001 SHALL have parameter: Nk, default 4, key length in 32-bit words (4/6/8); Nr = Nk+6 derived locally.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: decReset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid  input  1; req0_data  input  128  ciphertext block from requester 0; req0_ready  output  1.
REQ-005 SHALL have ports: req1_valid  input  1; req1_data  input  128  ciphertext block from requester 1; req1_ready  output  1.
REQ-006 SHALL have ports: dp_in  output  128  latched ciphertext to the shared inverse-round datapath; dp_load  output  1  load state = dp_in ^ initial round key.
REQ-007 SHALL have ports: dp_step  output  1  apply one inverse round; dp_last  output  1  apply final round (InvShiftRows, InvSubBytes, AddRoundKey); dp_round  output  4  current round index.
REQ-008 SHALL have port: dp_result  input  128  datapath output, valid during the FINAL cycle.
REQ-009 SHALL have ports: out_valid  output  1; out_ready  input  1; out_data  output  128  plaintext; out_id  output  1  requester that owns out_data.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, ROUND, FINAL, OUT.
REQ-012 IDLE: reqN_ready SHALL equal the grant to N; all other states drive both readies 0.
REQ-013 Arbitration SHALL be round-robin: a single valid requester is granted; if both are valid, the requester selected by 1-bit pointer ptr is granted.
REQ-014 On an accept (valid & ready), ptr SHALL become the other requester; ptr SHALL be unchanged when no accept occurs.
REQ-015 On accept, the FSM SHALL latch reqN_data into dp_in and N into an owner register, then go to LOAD.
REQ-016 LOAD (1 cycle): dp_load=1, dp_round=0; next state ROUND with dp_round=1.
REQ-017 ROUND: dp_step=1; dp_round SHALL increment each cycle from 1 to Nr-1 (Nr-1 cycles); after dp_round=Nr-1 the next state is FINAL.
REQ-018 FINAL (1 cycle): dp_last=1, dp_round=Nr; at the end of the cycle dp_result SHALL be captured into out_data and owner into out_id; next state OUT.
REQ-019 At most one of dp_load, dp_step, dp_last SHALL be high in any cycle; all three SHALL be 0 in IDLE and OUT.
REQ-020 OUT: out_valid=1; out_data and out_id SHALL stay stable until out_valid & out_ready; on that edge out_valid drops and the FSM returns to IDLE.
REQ-021 Latency: out_valid SHALL rise exactly Nr+2 cycles after the accept edge (12 for Nk=4, 14 for Nk=6, 16 for Nk=8).
REQ-022 No new request SHALL be accepted before OUT completes (one block in flight); a return to IDLE on cycle T allows acceptance in cycle T.
REQ-023 reqN_valid deasserting while not granted SHALL have no effect; reqN_data SHALL be sampled only on the accept edge.
REQ-024 dp_round SHALL be 4 bits and never exceed Nr; it SHALL hold its value in OUT and be 0 in IDLE.

Reset
REQ-025 With decReset high at a rising edge: FSM=IDLE, ptr=0, dp_round=0, dp_in=0, out_data=0, out_id=0, out_valid=0, busy=0; decReset SHALL take priority over every other input.
REQ-026 Reset asserted during LOAD/ROUND/FINAL/OUT SHALL discard the in-flight block; no out_valid SHALL follow for that block.
REQ-027 While decReset is high, both readies SHALL be 0.

Verification
REQ-028 Nk=4, shared datapath instantiated with key 000102030405060708090a0b0c0d0e0f; req0 sends 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, out_id=0, out_valid 12 cycles after accept.
REQ-029 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; each out_id matches its grant order.
REQ-030 out_ready held 0 for 5 cycles in OUT -> out_valid, out_data, out_id stable, both readies 0, no dp_* pulse.
REQ-031 decReset pulsed at dp_round=5 -> next cycle busy=0, out_valid=0, ptr=0; a following req1 block decrypts correctly.
REQ-032 Nk=8, key 000102...1e1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233445566778899aabbccddeeff, out_valid 16 cycles after accept; dp_round sequence 0,1..13,14.
